// File: rtl/uart_btn_tx_if.sv
// Board-side signal bundle for the button-driven UART transmitter.
// master = board/stimulus side, slave = transmitter side.
interface uart_btn_tx_if;
  logic       BTN1;
  logic [3:0] SW;
  logic       Dout;
  logic       Busy;

  modport master (
    output BTN1,
    output SW,
    input  Dout,
    input  Busy
  );

  modport slave (
    input  BTN1,
    input  SW,
    output Dout,
    output Busy
  );
endinterface

// File: rtl/uart_btn_tx.sv
// Button-driven UART transmitter: first BTN1 press arms, second press sends one
// 8N1 frame carrying the ASCII hex digit of SW. Dout idles high.
module uart_btn_tx #(
  parameter int unsigned CLK_FREQ  = 125_000_000,
  parameter int unsigned BAUD_RATE = 115_200
) (
  input logic          CLK,
  input logic          RST,
  uart_btn_tx_if.slave bus
);

  localparam int unsigned BaudDiv = CLK_FREQ / BAUD_RATE;
  localparam int unsigned CntW    = (BaudDiv > 1) ? $clog2(BaudDiv) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(BaudDiv - 1);

  typedef enum logic [1:0] {StIdle, StStart, StTx} state_e;

  // Button path
  logic       sync1_q, sync2_q, prev_q;
  logic [1:0] fill_q;      // marks when sync2_q holds a real sample after reset
  logic       seen_low_q;  // a held-across-reset button must be released first
  logic       press;

  // Transmitter state
  state_e          state_q;
  logic            dout_q;
  logic            busy_q;
  logic [CntW-1:0] baud_cnt_q;
  logic [3:0]      bit_idx_q;
  logic [8:0]      tx_shift_q;  // remaining data bits, stop bit fed in from the top
  logic [7:0]      hex_char;

  // Synchronize BTN1, track pipeline fill and first low level since reset
  always_ff @(posedge CLK) begin
    if (!RST) begin
      sync1_q    <= 1'b0;
      sync2_q    <= 1'b0;
      prev_q     <= 1'b0;
      fill_q     <= 2'b00;
      seen_low_q <= 1'b0;
    end else begin
      sync1_q <= bus.BTN1;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
      fill_q  <= {fill_q[0], 1'b1};
      if (fill_q[1] && !sync2_q) begin
        seen_low_q <= 1'b1;
      end
    end
  end

  // One-cycle press pulse on a genuine rising edge of the synchronized button
  always_comb begin
    press = fill_q[1] & seen_low_q & sync2_q & ~prev_q;
  end

  // ASCII hex digit of SW: '0'..'9', 'A'..'F'
  always_comb begin
    hex_char = 8'h00;
    if (bus.SW < 4'd10) begin
      hex_char = 8'h30 + {4'h0, bus.SW};
    end else begin
      hex_char = 8'h37 + {4'h0, bus.SW};
    end
  end

  // Control FSM with registered Dout/Busy
  always_ff @(posedge CLK) begin
    if (!RST) begin
      state_q    <= StIdle;
      dout_q     <= 1'b1;
      busy_q     <= 1'b0;
      baud_cnt_q <= '0;
      bit_idx_q  <= 4'd0;
      tx_shift_q <= 9'd0;
    end else begin
      unique case (state_q)
        StIdle: begin
          dout_q <= 1'b1;
          busy_q <= 1'b0;
          if (press) begin
            state_q <= StStart;
            busy_q  <= 1'b1;
          end
        end
        StStart: begin
          dout_q <= 1'b1;
          busy_q <= 1'b1;
          if (press) begin
            state_q    <= StTx;
            tx_shift_q <= {1'b1, hex_char};
            dout_q     <= 1'b0;  // start bit on the entry edge
            bit_idx_q  <= 4'd0;
            baud_cnt_q <= '0;
          end
        end
        StTx: begin
          busy_q <= 1'b1;
          if (baud_cnt_q == CntMax) begin
            baud_cnt_q <= '0;
            if (bit_idx_q == 4'd9) begin
              state_q <= StIdle;
              busy_q  <= 1'b0;
              dout_q  <= 1'b1;
            end else begin
              bit_idx_q  <= bit_idx_q + 4'd1;
              dout_q     <= tx_shift_q[0];
              tx_shift_q <= {1'b1, tx_shift_q[8:1]};
            end
          end else begin
            baud_cnt_q <= baud_cnt_q + 1'b1;
          end
        end
        default: begin
          state_q <= StIdle;
          dout_q  <= 1'b1;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.Dout = dout_q;
  assign bus.Busy = busy_q;

endmodule

// File: tb/tb_uart_btn_tx.sv
// Self-checking bench for uart_btn_tx: table-driven and random frames compared
// against a reference model of the 8N1 line waveform.
module tb_uart_btn_tx;

  localparam int unsigned BaudDiv = 10;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  uart_btn_tx_if tif ();

  uart_btn_tx #(
    .CLK_FREQ (1_152_000),
    .BAUD_RATE(115_200)
  ) dut (
    .CLK(clk),
    .RST(rst),
    .bus(tif)
  );

  typedef struct {
    logic [3:0] sw;
    logic [7:0] exp;
  } vec_t;

  int vectors     = 0;
  int miscompares = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: ASCII hex digit of a nibble
  function automatic logic [7:0] hex_ascii(input logic [3:0] v);
    if (v < 4'd10) return 8'd48 + 8'(v);
    return 8'd65 + 8'(v) - 8'd10;
  endfunction

  // Press BTN1 and wait for Busy; press must register on the 3rd edge
  task automatic press_wait_busy(output bit ok);
    ok = 1'b0;
    tif.BTN1 = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (i == 3) tif.BTN1 = 1'b0;
      if (tif.Busy === 1'b1) begin
        check("arm_latency", 32'(i), 32'd3);
        ok = 1'b1;
        break;
      end
    end
    tif.BTN1 = 1'b0;
    if (!ok) check("arm_timeout", 32'd0, 32'd1);
  endtask

  // Arm, send, and compare every cycle of the frame against the line model
  task automatic run_frame(input logic [3:0] sw, input logic [7:0] exp, input bit disturb,
                           input int abort_at);
    bit         ok;
    logic [9:0] frame;
    tif.SW = sw;
    press_wait_busy(ok);
    if (!ok) return;
    repeat (20) begin
      @(negedge clk);
      check("armed_busy", 32'(tif.Busy), 32'd1);
      check("armed_dout", 32'(tif.Dout), 32'd1);
    end
    frame = {1'b1, exp, 1'b0};
    ok = 1'b0;
    tif.BTN1 = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (i == 3) tif.BTN1 = 1'b0;
      if (tif.Dout === 1'b0) begin
        check("start_latency", 32'(i), 32'd3);
        ok = 1'b1;
        break;
      end
    end
    tif.BTN1 = 1'b0;
    if (!ok) begin
      check("start_timeout", 32'd0, 32'd1);
      return;
    end
    for (int k = 0; k < 10 * BaudDiv; k++) begin
      if (k > 0) @(negedge clk);
      if (k == abort_at) begin
        rst = 1'b0;
        @(negedge clk);
        check("abort_dout", 32'(tif.Dout), 32'd1);
        check("abort_busy", 32'(tif.Busy), 32'd0);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("abort_idle", 32'(tif.Busy), 32'd0);
        return;
      end
      if (disturb) begin
        if (k == 20) tif.BTN1 = 1'b1;
        if (k == 26) tif.BTN1 = 1'b0;
        if (k == 30) tif.SW = ~sw;
      end
      check("frame_bit", 32'(tif.Dout), 32'(frame[k / BaudDiv]));
      check("frame_busy", 32'(tif.Busy), 32'd1);
    end
    @(negedge clk);
    check("end_busy", 32'(tif.Busy), 32'd0);
    check("end_dout", 32'(tif.Dout), 32'd1);
    if (disturb) begin
      repeat (20) begin
        @(negedge clk);
        check("no_rearm", 32'(tif.Busy), 32'd0);
      end
    end
  endtask

  initial begin
    vec_t       tbl[6];
    bit         ok;
    logic [3:0] s;

    tbl[0] = '{4'h1, 8'h31};
    tbl[1] = '{4'h2, 8'h32};
    tbl[2] = '{4'hA, 8'h41};
    tbl[3] = '{4'h0, 8'h30};
    tbl[4] = '{4'h9, 8'h39};
    tbl[5] = '{4'hF, 8'h46};

    rst      = 1'b0;
    tif.BTN1 = 1'b0;
    tif.SW   = 4'h0;
    repeat (5) @(negedge clk);
    check("reset_dout", 32'(tif.Dout), 32'd1);
    check("reset_busy", 32'(tif.Busy), 32'd0);
    rst = 1'b1;
    repeat (100) begin
      @(negedge clk);
      check("idle_dout", 32'(tif.Dout), 32'd1);
      check("idle_busy", 32'(tif.Busy), 32'd0);
    end

    for (int i = 0; i < 6; i++) begin
      run_frame(tbl[i].sw, tbl[i].exp, 1'b0, -1);
    end

    // Presses and SW changes during TX are ignored
    run_frame(4'h7, 8'h37, 1'b1, -1);

    // Reset mid-frame (bit 4), then a complete fresh frame
    run_frame(4'h5, 8'h35, 1'b0, 45);
    run_frame(4'hC, 8'h43, 1'b0, -1);

    // Reset while armed
    tif.SW = 4'h6;
    press_wait_busy(ok);
    rst = 1'b0;
    @(negedge clk);
    check("start_rst_busy", 32'(tif.Busy), 32'd0);
    check("start_rst_dout", 32'(tif.Dout), 32'd1);
    rst = 1'b1;
    repeat (5) @(negedge clk);
    check("start_rst_idle", 32'(tif.Busy), 32'd0);

    // Button held across reset must not produce a press
    rst      = 1'b0;
    tif.BTN1 = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (20) begin
      @(negedge clk);
      check("held_no_press", 32'(tif.Busy), 32'd0);
    end
    tif.BTN1 = 1'b0;
    repeat (5) @(negedge clk);
    run_frame(4'h3, 8'h33, 1'b0, -1);

    // Random values against the model
    for (int i = 0; i < 8; i++) begin
      s = 4'($urandom_range(0, 15));
      run_frame(s, hex_ascii(s), 1'($urandom_range(0, 1)), -1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
